row_pulse_gate: RTL

ROW_PULSE_GATE -- requirements
Module: row_pulse_gate

---
 rtl/row_pulse_gate.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/row_pulse_gate.sv
// row_pulse_gate: gates and stretches divided laser pulses into rows.
// Asynchronous pulse and velocity inputs are synchronized. Edges inside an
// active row are counted and stretched. A row ends when it reaches its
// programmed length or when constant_v falls. When en_rowpack is low, every
// edge passes straight through to the stretcher (bypass).

module row_pulse_gate #(
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_W     = 4,
   parameter int CNT_W       = 16
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             divided_pulse,
   input  logic             constant_v,
   input  logic             en_rowpack,
   input  logic [CNT_W-1:0] row_size,
   output logic             gated_pulse,
   output logic             row_active,
   output logic             row_done,
   output logic [CNT_W-1:0] pulse_index,
   output logic [CNT_W-1:0] row_count,
   output logic             overrun
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_ROW   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [7:0] WIDTH_RELOAD = 8'(PULSE_W - 1);

   // Bit 0 carries divided_pulse and bit 1 carries constant_v through the
   // same flop chain, so both inputs see identical latency.
   logic [SYNC_STAGES-1:0][1:0] sync_q;
   logic [1:0]                  dly_q;
   logic [1:0]                  sync_s;
   logic [SYNC_STAGES+1:0]      prime_q;
   logic                        primed;
   logic                        dp_rise_q;
   logic                        cv_rise_q;
   logic                        cv_fall_q;
   logic                        cv_lvl;

   logic [1:0]       state_q;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] row_limit;
   logic [CNT_W-1:0] index_plus;
   logic [7:0]       width_cnt;

   logic fire;
   logic cnt_inc;
   logic done_enter;
   logic load_limit;
   logic clr_index;

   assign sync_s     = sync_q[SYNC_STAGES-1];
   assign primed     = prime_q[SYNC_STAGES+1];
   assign cv_lvl     = dly_q[1];
   assign index_plus = pulse_index + CNT_W'(1);
   assign row_active = (state_q == S_ROW);

   // Synchronizer chains plus a one-flop delay used for edge detection.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= '0;
      end else begin
         if (SYNC_STAGES > 1)
            sync_q <= {sync_q[SYNC_STAGES-2:0], {constant_v, divided_pulse}};
         else
            sync_q[0] <= {constant_v, divided_pulse};
         dly_q  <= sync_s;
      end
   end

   // After reset the chains fill up from zero. Edges are masked until real
   // input data has reached the delay flop, so an input that is already high
   // when reset releases is not seen as a new rising edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) prime_q <= '0;
      else        prime_q <= {prime_q[SYNC_STAGES:0], 1'b1};
   end

   // Registered edge strobes. The extra register sets the documented
   // latency and keeps the FSM decode away from the synchronizer outputs.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_rise_q <= 1'b0;
         cv_rise_q <= 1'b0;
         cv_fall_q <= 1'b0;
      end else begin
         dp_rise_q <= primed &  sync_s[0] & ~dly_q[0];
         cv_rise_q <= primed &  sync_s[1] & ~dly_q[1];
         cv_fall_q <= primed & ~sync_s[1] &  dly_q[1];
      end
   end

   // Next-state and row-control decode. Disabling row packing overrides
   // everything else and forces IDLE.
   always_comb begin
      state_nxt  = state_q;
      fire       = 1'b0;
      cnt_inc    = 1'b0;
      done_enter = 1'b0;
      load_limit = 1'b0;
      clr_index  = 1'b0;
      case (state_q)
         S_IDLE:  state_nxt = S_ARMED;
         S_ARMED: begin
            if (cv_rise_q) begin
               state_nxt  = S_ROW;
               load_limit = 1'b1;
            end
         end
         S_ROW: begin
            if (cv_fall_q) begin
               // A short row ends here. A pulse edge in the same cycle is dropped.
               state_nxt  = S_DONE;
               done_enter = 1'b1;
            end else if (dp_rise_q) begin
               fire    = 1'b1;
               cnt_inc = 1'b1;
               if ((row_limit != '0) && (index_plus == row_limit)) begin
                  state_nxt  = S_DONE;
                  done_enter = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (!cv_lvl) state_nxt = S_ARMED;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (!en_rowpack) begin
         state_nxt  = S_IDLE;
         clr_index  = 1'b1;
         cnt_inc    = 1'b0;
         done_enter = 1'b0;
         load_limit = 1'b0;
         fire       = (state_q == S_IDLE) & dp_rise_q;
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nxt;
   end

   // Row limit, pulse index, completed-row count and the row_done strobe.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         row_limit   <= '0;
         pulse_index <= '0;
         row_count   <= '0;
         row_done    <= 1'b0;
      end else begin
         if (load_limit) row_limit <= row_size;
         if (clr_index || load_limit) pulse_index <= '0;
         else if (cnt_inc)            pulse_index <= index_plus;
         if (done_enter) row_count <= row_count + CNT_W'(1);
         row_done <= done_enter;
      end
   end

   // Pulse stretcher. A fire while the output is already high reloads the
   // width counter, so the output stays high continuously.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         gated_pulse <= 1'b0;
         width_cnt   <= '0;
      end else if (fire) begin
         gated_pulse <= 1'b1;
         width_cnt   <= WIDTH_RELOAD;
      end else if (width_cnt != '0) begin
         width_cnt   <= width_cnt - 8'd1;
      end else begin
         gated_pulse <= 1'b0;
      end
   end

   // Sticky overrun flag, set by a fire that lands on an active pulse.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)                    overrun <= 1'b0;
      else if (fire && gated_pulse) overrun <= 1'b1;
   end

endmodule
